// File: rtl/load_store_unit.sv
// Load/store master for a word-organised data memory.
// Byte/halfword/word access; sub-word stores merge through one register stage.
module load_store_unit #(
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_error,
  output logic                      mem_wEn,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]               mem_write_data,
  input  logic [31:0]               mem_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    RESP
  } state_t;

  state_t                    state_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_d;
  logic [31:0]               merged_q;
  logic [31:0]               merged_d;

  logic        accept;
  logic        err;
  logic        range_err;
  logic        is_word;
  logic [31:0] addr_hi;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign is_word   = (req_size == 2'b10);
  assign addr_hi   = req_addr >> MEM_ADDR_WIDTH;
  assign range_err = |addr_hi;
  assign addr_d    = {req_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
  assign byte_sh   = {req_addr[1:0], 3'b000};
  assign half_sh   = {req_addr[1], 4'b0000};
  assign shifted   = mem_read_data >> byte_sh;

  always_comb begin
    err = 1'b1;
    unique case (req_size)
      2'b00:   err = range_err;
      2'b01:   err = range_err | req_addr[0];
      2'b10:   err = range_err | (|req_addr[1:0]);
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    load_data = shifted;
    unique case (req_size)
      2'b00: load_data = req_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_data = req_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Replicate the store data across lanes, then keep only the target lane(s).
  always_comb begin
    lane_mask = 32'h0000_00ff << byte_sh;
    lane_data = {4{req_wdata[7:0]}};
    if (req_size == 2'b01) begin
      lane_mask = 32'h0000_ffff << half_sh;
      lane_data = {2{req_wdata[15:0]}};
    end
  end

  assign merged_d = (mem_read_data & ~lane_mask) | (lane_data & lane_mask);

  always_comb begin
    mem_wEn        = 1'b0;
    mem_address    = '0;
    mem_write_data = 32'h0;
    if (!reset && state_q == MERGE) begin
      mem_wEn        = 1'b1;
      mem_address    = addr_q;
      mem_write_data = merged_q;
    end else if (accept && !err) begin
      mem_address = addr_d;
      if (req_we && is_word) begin
        mem_wEn        = 1'b1;
        mem_write_data = req_wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      merged_q   <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (err) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else if (!req_we) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
            end else if (is_word) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state_q  <= MERGE;
              addr_q   <= addr_d;
              merged_q <= merged_d;
            end
          end
        end
        MERGE: begin
          state_q    <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Behavioural word memory plus a response scoreboard queue.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_wEn;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] mem [0:16383];
  int          wen_cnt = 0;
  logic [15:0] last_waddr;
  logic [31:0] last_wdata;
  logic        poke_en = 1'b0;
  logic [13:0] poke_idx;
  logic [31:0] poke_data;

  load_store_unit #(.MEM_ADDR_WIDTH(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_wEn        (mem_wEn),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[15:2]];

  always @(posedge clock) begin
    if (mem_wEn) begin
      mem[mem_address[15:2]] <= mem_write_data;
      wen_cnt    <= wen_cnt + 1;
      last_waddr <= mem_address;
      last_wdata <= mem_write_data;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance to the next falling edge and retire any response.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (resp_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: got rdata=%h err=%b, required none",
                 resp_rdata, resp_error);
      end else begin
        e = exp_q.pop_front();
        if (resp_rdata !== e.rdata || resp_error !== e.err) begin
          n_fail++;
          $display("FAIL resp_data: got rdata=%h err=%b, required %h err=%b",
                   resp_rdata, resp_error, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic poke(input logic [13:0] idx, input logic [31:0] data);
    poke_idx  = idx;
    poke_data = data;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic set_req(input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
  endtask

  task automatic do_req(input string name, input logic we,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat);
    exp_t e;
    int   lat;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: got req_ready=%b, required 1", name, req_ready);
    end
    set_req(we, size, uns, addr, wdata);
    e.rdata = exp_rd;
    e.err   = exp_err;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, required %0d",
               name, lat, exp_lat);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (req_ready !== 1'b0 || mem_wEn !== 1'b0 || mem_address !== 16'h0 ||
          mem_write_data !== 32'h0 || resp_valid !== 1'b0 ||
          resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got rdy=%b wen=%b a=%h wd=%h rv=%b rd=%h re=%b, required all 0",
                 req_ready, mem_wEn, mem_address, mem_write_data,
                 resp_valid, resp_rdata, resp_error);
      end
    end
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", req_ready);
    end
    repeat (3) tick();
  endtask

  task automatic test_word();
    int w0 = wen_cnt;
    do_req("wstore", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    n_tests++;
    if (wen_cnt - w0 !== 1 || last_waddr !== 16'h0010 ||
        last_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wstore_write: got %0d writes a=%h d=%h, required 1 a=0010 d=deadbeef",
               wen_cnt - w0, last_waddr, last_wdata);
    end
    do_req("wload", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
  endtask

  task automatic test_subword_store();
    int w0;
    poke(14'd8, 32'h11223344);
    poke(14'd9, 32'h55667788);
    w0 = wen_cnt;
    do_req("bstore", 1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA, 32'h0, 1'b0, 2);
    n_tests++;
    if (wen_cnt - w0 !== 1 || last_waddr !== 16'h0020 ||
        mem[8] !== 32'h11AA3344) begin
      n_fail++;
      $display("FAIL bstore_rmw: got %0d writes a=%h word=%h, required 1 a=0020 word=11aa3344",
               wen_cnt - w0, last_waddr, mem[8]);
    end
    w0 = wen_cnt;
    do_req("hstore", 1'b1, 2'b01, 1'b0, 32'h26, 32'hCAFEBEEF, 32'h0, 1'b0, 2);
    n_tests++;
    if (wen_cnt - w0 !== 1 || mem[9] !== 32'hBEEF7788) begin
      n_fail++;
      $display("FAIL hstore_rmw: got %0d writes word=%h, required 1 word=beef7788",
               wen_cnt - w0, mem[9]);
    end
  endtask

  task automatic test_sign_ext();
    poke(14'd12, 32'h80FF7F01);
    do_req("lb_31", 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'h0000007F, 1'b0, 1);
    do_req("lb_32", 1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 32'hFFFFFFFF, 1'b0, 1);
    do_req("lbu_33", 1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 32'h00000080, 1'b0, 1);
    do_req("lhu_32", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h000080FF, 1'b0, 1);
    do_req("lh_32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF80FF, 1'b0, 1);
    do_req("lh_30", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'h00007F01, 1'b0, 1);
  endtask

  task automatic test_errors();
    int w0 = wen_cnt;
    do_req("e_wmis", 1'b1, 2'b10, 1'b0, 32'h13, 32'h01020304, 32'h0, 1'b1, 1);
    do_req("e_hmis", 1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 32'h0, 1'b1, 1);
    do_req("e_range", 1'b0, 2'b10, 1'b0, 32'h00010000, 32'h0, 32'h0, 1'b1, 1);
    do_req("e_size_ld", 1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 32'h0, 1'b1, 1);
    do_req("e_size_st", 1'b1, 2'b11, 1'b0, 32'h30, 32'h55555555, 32'h0, 1'b1, 1);
    do_req("e_bst_range", 1'b1, 2'b00, 1'b0, 32'h80000030, 32'h66, 32'h0, 1'b1, 1);
    n_tests++;
    if (wen_cnt - w0 !== 0 || mem[4] !== 32'hDEADBEEF ||
        mem[12] !== 32'h80FF7F01) begin
      n_fail++;
      $display("FAIL err_nowrite: got %0d writes w10=%h w30=%h, required 0 deadbeef 80ff7f01",
               wen_cnt - w0, mem[4], mem[12]);
    end
  endtask

  task automatic test_reset_in_merge();
    int w0;
    poke(14'd16, 32'h0);
    w0 = wen_cnt;
    set_req(1'b1, 2'b00, 1'b0, 32'h40, 32'h5A);
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (mem_wEn !== 1'b1) begin
      n_fail++;
      $display("FAIL merge_wen: got mem_wEn=%b, required 1", mem_wEn);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (mem_wEn !== 1'b0) begin
      n_fail++;
      $display("FAIL merge_reset_wen: got mem_wEn=%b, required 0", mem_wEn);
    end
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL merge_reset_ready: got %b, required 1", req_ready);
    end
    repeat (4) tick();
    n_tests++;
    if (wen_cnt - w0 !== 0 || mem[16] !== 32'h0) begin
      n_fail++;
      $display("FAIL merge_reset_mem: got %0d writes word=%h, required 0 writes word=0",
               wen_cnt - w0, mem[16]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    int          acc [3];
    int          cyc;
    int          i;
    exp_t        e;
    vals[0] = 32'hA1B2C3D4;
    vals[1] = 32'h0F1E2D3C;
    vals[2] = 32'h99887766;
    for (int k = 0; k < 3; k++) poke(14'd20 + 14'(k), vals[k]);
    cyc = 0;
    i   = 0;
    set_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
    while (i < 3 && cyc < 20) begin
      if (req_ready === 1'b1) begin
        acc[i]  = cyc;
        e.rdata = vals[i];
        e.err   = 1'b0;
        exp_q.push_back(e);
        tick();
        cyc++;
        i++;
        if (i < 3) set_req(1'b0, 2'b10, 1'b0, 32'h50 + 32'(4 * i), 32'h0);
        else req_valid = 1'b0;
      end else begin
        n_tests++;
        if (resp_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_stall: req_ready low without resp_valid at cycle %0d", cyc);
        end
        tick();
        cyc++;
      end
    end
    req_valid = 1'b0;
    n_tests++;
    if (i !== 3) begin
      n_fail++;
      $display("FAIL b2b_accepts: got %0d accepts, required 3", i);
    end else begin
      n_tests++;
      if (acc[1] - acc[0] !== 2 || acc[2] - acc[1] !== 2) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d,%0d cycles, required 2,2",
                 acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    poke_idx     = 14'd0;
    poke_data    = 32'h0;
    test_reset();
    test_word();
    test_subword_store();
    test_sign_ext();
    test_errors();
    test_reset_in_merge();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL missing_resp: got %0d outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
